// File: rtl/lectura_operandos_sincronizada.sv
// ----------------------------------------------------------------------------
// lectura_operandos_sincronizada
//
// Operand read stage for the multiplier datapath. The raw operand switches
// and the start button are brought into the reloj domain. The button is
// debounced, and on each debounced press both operands are captured and
// offered to the multiplier under a valid/ready handshake.
//
// Parameters
//   ANCHO           operand width in bits (>=1)
//   CICLOS_ESTABLE  cycles the synchronised button must disagree with the
//                   debounced level before that level flips (>=1)
//
// Ports
//   reloj                  in   clock, rising edge
//   reinicio               in   asynchronous active-high reset
//   operandoEntradaA/B     in   raw switch operands (asynchronous)
//   iniciarMultiplicacion  in   raw start button, active-high, bouncy
//   listoMultiplicador     in   multiplier ready (handshake ready)
//   operandoSalidaA/B      out  captured operands
//   banderaValida          out  captured operands valid (handshake valid)
//   ledOperandoA/B         out  switches differ from captured operand
//   banderaDescartado      out  sticky flag: a press arrived while busy
// ----------------------------------------------------------------------------
module lectura_operandos_sincronizada #(
    parameter int ANCHO          = 4,
    parameter int CICLOS_ESTABLE = 4
) (
    input  logic             reloj,
    input  logic             reinicio,
    input  logic [ANCHO-1:0] operandoEntradaA,
    input  logic [ANCHO-1:0] operandoEntradaB,
    input  logic             iniciarMultiplicacion,
    input  logic             listoMultiplicador,
    output logic [ANCHO-1:0] operandoSalidaA,
    output logic [ANCHO-1:0] operandoSalidaB,
    output logic             banderaValida,
    output logic             ledOperandoA,
    output logic             ledOperandoB,
    output logic             banderaDescartado
);

    // Counter must hold 0..CICLOS_ESTABLE-1; keep at least one bit.
    localparam int            CW         = (CICLOS_ESTABLE > 1) ? $clog2(CICLOS_ESTABLE) : 1;
    localparam logic [CW-1:0] CUENTA_MAX = CW'(CICLOS_ESTABLE - 1);

    typedef enum logic {
        REPOSO = 1'b0,
        VALIDO = 1'b1
    } estado_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers, one pair per operand bit.
    // ------------------------------------------------------------------
    logic [ANCHO-1:0] w_sinc_a;
    logic [ANCHO-1:0] w_sinc_b;

    genvar gi;
    generate
        for (gi = 0; gi < ANCHO; gi++) begin : g_sinc
            logic r_meta_a;
            logic r_meta_b;
            logic r_sinc_a;
            logic r_sinc_b;

            always_ff @(posedge reloj or posedge reinicio) begin
                if (reinicio) begin
                    r_meta_a <= 1'b0;
                    r_meta_b <= 1'b0;
                    r_sinc_a <= 1'b0;
                    r_sinc_b <= 1'b0;
                end else begin
                    r_meta_a <= operandoEntradaA[gi];
                    r_meta_b <= operandoEntradaB[gi];
                    r_sinc_a <= r_meta_a;
                    r_sinc_b <= r_meta_b;
                end
            end

            assign w_sinc_a[gi] = r_sinc_a;
            assign w_sinc_b[gi] = r_sinc_b;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer.
    // ------------------------------------------------------------------
    logic          r_btn_meta;
    logic          r_btn_sinc;
    logic [CW-1:0] r_cuenta;
    logic          r_nivel_deb;
    logic          r_nivel_deb_q;
    logic          w_inicio;

    always_ff @(posedge reloj or posedge reinicio) begin
        if (reinicio) begin
            r_btn_meta    <= 1'b0;
            r_btn_sinc    <= 1'b0;
            r_cuenta      <= '0;
            r_nivel_deb   <= 1'b0;
            r_nivel_deb_q <= 1'b0;
        end else begin
            r_btn_meta    <= iniciarMultiplicacion;
            r_btn_sinc    <= r_btn_meta;
            r_nivel_deb_q <= r_nivel_deb;
            if (r_btn_sinc != r_nivel_deb) begin
                // Disagreement must persist CICLOS_ESTABLE cycles in a row;
                // the level flips on the last of them.
                if (r_cuenta == CUENTA_MAX) begin
                    r_nivel_deb <= ~r_nivel_deb;
                    r_cuenta    <= '0;
                end else begin
                    r_cuenta <= r_cuenta + 1'b1;
                end
            end else begin
                r_cuenta <= '0;
            end
        end
    end

    // One-cycle pulse on each debounced press; releases produce nothing.
    assign w_inicio = r_nivel_deb & ~r_nivel_deb_q;

    // ------------------------------------------------------------------
    // Capture / handshake FSM.
    // ------------------------------------------------------------------
    estado_t          r_estado;
    estado_t          w_estado_next;
    logic [ANCHO-1:0] r_op_a;
    logic [ANCHO-1:0] r_op_b;
    logic [ANCHO-1:0] w_op_a_next;
    logic [ANCHO-1:0] w_op_b_next;
    logic             r_valida;
    logic             w_valida_next;
    logic             r_descartado;
    logic             w_descartado_next;
    logic             r_led_a;
    logic             r_led_b;

    always_ff @(posedge reloj or posedge reinicio) begin
        if (reinicio) begin
            r_estado     <= REPOSO;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_valida     <= 1'b0;
            r_descartado <= 1'b0;
            r_led_a      <= 1'b0;
            r_led_b      <= 1'b0;
        end else begin
            r_estado     <= w_estado_next;
            r_op_a       <= w_op_a_next;
            r_op_b       <= w_op_b_next;
            r_valida     <= w_valida_next;
            r_descartado <= w_descartado_next;
            // Compare against the currently held operands, so the LEDs
            // trail the switches by one cycle.
            r_led_a      <= (w_sinc_a != r_op_a);
            r_led_b      <= (w_sinc_b != r_op_b);
        end
    end

    always_comb begin
        w_estado_next     = r_estado;
        w_op_a_next       = r_op_a;
        w_op_b_next       = r_op_b;
        w_valida_next     = r_valida;
        w_descartado_next = r_descartado;

        case (r_estado)
            REPOSO: begin
                // listoMultiplicador is deliberately ignored here.
                if (w_inicio) begin
                    w_op_a_next   = w_sinc_a;
                    w_op_b_next   = w_sinc_b;
                    w_valida_next = 1'b1;
                    w_estado_next = VALIDO;
                end
            end
            VALIDO: begin
                if (listoMultiplicador) begin
                    // Transfer: operands are kept, only valid drops.
                    w_valida_next = 1'b0;
                    w_estado_next = REPOSO;
                end
                // A press while busy (even on the transfer edge) is lost.
                if (w_inicio) begin
                    w_descartado_next = 1'b1;
                end
            end
            default: begin
                w_estado_next = REPOSO;
            end
        endcase
    end

    assign operandoSalidaA   = r_op_a;
    assign operandoSalidaB   = r_op_b;
    assign banderaValida     = r_valida;
    assign ledOperandoA      = r_led_a;
    assign ledOperandoB      = r_led_b;
    assign banderaDescartado = r_descartado;

endmodule

// File: tb/tb_lectura_operandos_sincronizada.sv
module tb_lectura_operandos_sincronizada;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] sw_a, sw_b, op_a, op_b;
    logic       btn, listo, valida, led_a, led_b, drop;

    logic [7:0] sw_a6, sw_b6, op_a6, op_b6;
    logic       btn6, listo6, valida6, led_a6, led_b6, drop6;

    int n_tests = 0;
    int n_fail  = 0;

    lectura_operandos_sincronizada #(.ANCHO(4), .CICLOS_ESTABLE(N)) u_dut (
        .reloj                 (clk),
        .reinicio              (rst),
        .operandoEntradaA      (sw_a),
        .operandoEntradaB      (sw_b),
        .iniciarMultiplicacion (btn),
        .listoMultiplicador    (listo),
        .operandoSalidaA       (op_a),
        .operandoSalidaB       (op_b),
        .banderaValida         (valida),
        .ledOperandoA          (led_a),
        .ledOperandoB          (led_b),
        .banderaDescartado     (drop)
    );

    lectura_operandos_sincronizada #(.ANCHO(8), .CICLOS_ESTABLE(1)) u_dut6 (
        .reloj                 (clk),
        .reinicio              (rst),
        .operandoEntradaA      (sw_a6),
        .operandoEntradaB      (sw_b6),
        .iniciarMultiplicacion (btn6),
        .listoMultiplicador    (listo6),
        .operandoSalidaA       (op_a6),
        .operandoSalidaB       (op_b6),
        .banderaValida         (valida6),
        .ledOperandoA          (led_a6),
        .ledOperandoB          (led_b6),
        .banderaDescartado     (drop6)
    );

    // ---------------- behavioural reference (N=4, ANCHO=4 instance) -------
    bit       m_s1_btn, m_s2_btn;
    bit [3:0] m_s1_a, m_s2_a, m_s1_b, m_s2_b;
    bit       m_nivel, m_nivel_q;
    int       m_since;          // edges since the debounced level last flipped
    bit       m_win[$];         // last N synchronised button samples
    bit       m_valid, m_drop, m_led_a, m_led_b;
    bit [3:0] m_op_a, m_op_b;

    task automatic model_reset();
        m_s1_btn = 0; m_s2_btn = 0;
        m_s1_a = 0; m_s2_a = 0; m_s1_b = 0; m_s2_b = 0;
        m_nivel = 0; m_nivel_q = 0;
        m_since = N;
        m_win.delete();
        for (int i = 0; i < N; i++) m_win.push_back(1'b0);
        m_valid = 0; m_drop = 0; m_led_a = 0; m_led_b = 0;
        m_op_a = 0; m_op_b = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valida", {31'd0, valida}, {31'd0, m_valid});
        chk("op_a", {28'd0, op_a}, {28'd0, m_op_a});
        chk("op_b", {28'd0, op_b}, {28'd0, m_op_b});
        chk("led_a", {31'd0, led_a}, {31'd0, m_led_a});
        chk("led_b", {31'd0, led_b}, {31'd0, m_led_b});
        chk("descartado", {31'd0, drop}, {31'd0, m_drop});
    endtask

    // Advance one clock: predict the post-edge state from the rules, then
    // compare shortly after the edge.
    task automatic tick();
        bit pulse, all_diff, n_led_a, n_led_b;
        int since;
        pulse = m_nivel & ~m_nivel_q;
        m_win.push_back(m_s2_btn);
        if (m_win.size() > N) void'(m_win.pop_front());
        since = (m_since < N) ? m_since + 1 : N;
        all_diff = 1;
        foreach (m_win[i]) if (m_win[i] == m_nivel) all_diff = 0;
        n_led_a = (m_s2_a != m_op_a);
        n_led_b = (m_s2_b != m_op_b);
        m_nivel_q = m_nivel;
        if (since >= N && all_diff) begin
            m_nivel = ~m_nivel;
            since = 0;
        end
        m_since = since;
        if (!m_valid) begin
            if (pulse) begin
                m_op_a = m_s2_a; m_op_b = m_s2_b; m_valid = 1;
            end
        end else begin
            if (pulse) m_drop = 1;
            if (listo) m_valid = 0;
        end
        m_led_a = n_led_a; m_led_b = n_led_b;
        m_s2_btn = m_s1_btn; m_s1_btn = btn;
        m_s2_a = m_s1_a; m_s1_a = sw_a;
        m_s2_b = m_s1_b; m_s1_b = sw_b;
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Assert reset mid-cycle; outputs must clear with no clock edge.
    task automatic apply_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_valida", {31'd0, valida}, 32'd0);
        chk("rst_op_a", {28'd0, op_a}, 32'd0);
        chk("rst_op_b", {28'd0, op_b}, 32'd0);
        chk("rst_leds", {30'd0, led_a, led_b}, 32'd0);
        chk("rst_descartado", {31'd0, drop}, 32'd0);
        chk("rst6_outs", {8'd0, op_a6, op_b6}, 32'd0);
        chk("rst6_flags", {28'd0, valida6, led_a6, led_b6, drop6}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int first1, first6, hi1;
        rst = 1'b1;
        sw_a = 0; sw_b = 0; btn = 0; listo = 0;
        sw_a6 = 0; sw_b6 = 0; btn6 = 0; listo6 = 0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // T2 + T6: clean presses on both instances, ready already high.
        sw_a = 4'h3; sw_b = 4'h5; sw_a6 = 8'hA5; sw_b6 = 8'h3C;
        btn = 1; btn6 = 1; listo = 1; listo6 = 1;
        first1 = 0; first6 = 0; hi1 = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (valida && first1 == 0) first1 = k;
            if (valida) hi1++;
            if (valida6 && first6 == 0) first6 = k;
        end
        chk("t2_latency", first1, 7);
        chk("t2_valid_cycles", hi1, 1);
        chk("t2_ops", {24'd0, op_a, op_b}, 32'h35);
        chk("t2_leds", {30'd0, led_a, led_b}, 32'd0);
        chk("t6_latency", first6, 4);
        chk("t6_ops", {16'd0, op_a6, op_b6}, 32'hA53C);

        // T3: hold ready low for 10 cycles while valid.
        btn = 0; listo = 0;
        repeat (8) tick();
        btn = 1;
        for (int k = 0; k < 20 && !valida; k++) tick();
        chk("t3_reached_valid", {31'd0, valida}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t3_hold_valid", {31'd0, valida}, 32'd1);
            chk("t3_hold_ops", {24'd0, op_a, op_b}, 32'h35);
        end
        listo = 1;
        tick();
        chk("t3_transfer", {31'd0, valida}, 32'd0);

        // T5: second press while busy, switches changed.
        btn = 0; listo = 0;
        repeat (8) tick();
        btn = 1;
        for (int k = 0; k < 20 && !valida; k++) tick();
        chk("t5_reached_valid", {31'd0, valida}, 32'd1);
        btn = 0;
        repeat (8) tick();
        sw_a = 4'hF; btn = 1;
        repeat (10) tick();
        chk("t5_descartado", {31'd0, drop}, 32'd1);
        chk("t5_op_a_kept", {28'd0, op_a}, 32'h3);
        chk("t5_led_a", {31'd0, led_a}, 32'd1);
        listo = 1;
        tick();

        // T4: bouncing press 1-0-1-0 at 2-cycle spacing, then held.
        btn = 0;
        repeat (8) tick();
        hi1 = 0;
        for (int k = 0; k < 8; k++) begin
            btn = (k % 4) < 2;
            tick();
            if (valida) hi1++;
        end
        btn = 1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (valida) hi1++;
        end
        chk("t4_single_transfer", hi1, 1);

        // T1: reset while VALIDO, then a fresh capture from REPOSO.
        btn = 0; listo = 0;
        repeat (8) tick();
        btn = 1;
        repeat (10) tick();
        chk("t1_pre_valid", {31'd0, valida}, 32'd1);
        apply_reset();
        sw_a = 4'h9; sw_b = 4'h6; btn = 1;
        repeat (10) tick();
        chk("t1_recapture", {23'd0, valida, op_a, op_b}, 32'h196);

        // Randomised traffic: glitches, presses, ready toggling, switch moves.
        listo = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7) == 0) btn = ~btn;
            listo = ($urandom_range(3) == 0);
            if ($urandom_range(9) == 0) sw_a = 4'($urandom);
            if ($urandom_range(9) == 0) sw_b = 4'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
